// File: rtl/recovery_ctrl.sv
// Exception-recovery sequencer: drains stores, flushes, walks the rename map back,
// then redirects fetch to the handler. Owns the global flush/freeze controls.
//   state    | meaning
//   IDLE     | normal operation, freezes pass through from full flags
//   DRAIN    | waiting for committed stores to leave the LSQ
//   FLUSH    | one-cycle pipeline flush pulse
//   WALK     | restoring up to WALK_W rename entries per cycle
//   REDIRECT | one-cycle fetch redirect to the handler
module recovery_ctrl #(
    parameter int              PC_W       = 32,
    parameter int              ROB_DEPTH  = 16,
    parameter int              WALK_W     = 3,
    parameter logic [PC_W-1:0] HANDLER_PC = 32'h1c00_0000,
    localparam int             CW         = $clog2(ROB_DEPTH) + 1,
    localparam int             WCW        = $clog2(WALK_W + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            excep_valid,
    input  logic [PC_W-1:0] excep_pc,
    input  logic [4:0]      excep_cause,
    input  logic [CW-1:0]   rob_used,
    input  logic            lsq_busy,
    input  logic            full_any,
    input  logic            fifo_full,
    output logic            flush,
    output logic            freeze_front,
    output logic            freeze_back,
    output logic            walk_valid,
    output logic [WCW-1:0]  walk_cnt,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output logic [PC_W-1:0] epc,
    output logic [4:0]      ecause,
    output logic            busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_FLUSH,
        S_WALK,
        S_REDIRECT
    } state_t;

    localparam logic [CW-1:0] DEPTH_C = CW'(ROB_DEPTH);
    localparam logic [CW-1:0] WALK_C  = CW'(WALK_W);

    state_t          state_q, state_d;
    logic [CW-1:0]   remaining_q, remaining_d;
    logic [PC_W-1:0] epc_q, epc_d;
    logic [4:0]      ecause_q, ecause_d;

    logic [CW-1:0]   used_clamped;
    logic [CW-1:0]   walk_amt;

    assign used_clamped = (rob_used > DEPTH_C) ? DEPTH_C : rob_used;
    assign walk_amt     = (remaining_q < WALK_C) ? remaining_q : WALK_C;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            epc_q       <= '0;
            ecause_q    <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            epc_q       <= epc_d;
            ecause_q    <= ecause_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        epc_d       = epc_q;
        ecause_d    = ecause_q;
        case (state_q)
            S_IDLE: begin
                if (excep_valid) begin
                    epc_d       = excep_pc;
                    ecause_d    = excep_cause;
                    remaining_d = used_clamped;
                    state_d     = lsq_busy ? S_DRAIN : S_FLUSH;
                end
            end
            S_DRAIN: begin
                if (!lsq_busy) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                state_d = (remaining_q != '0) ? S_WALK : S_REDIRECT;
            end
            S_WALK: begin
                remaining_d = remaining_q - walk_amt;
                if (remaining_q <= WALK_C) state_d = S_REDIRECT;
            end
            S_REDIRECT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        flush          = 1'b0;
        freeze_front   = 1'b0;
        freeze_back    = 1'b0;
        walk_valid     = 1'b0;
        walk_cnt       = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        busy           = 1'b1;
        case (state_q)
            S_IDLE: begin
                freeze_front = full_any | excep_valid;
                freeze_back  = fifo_full;
                busy         = 1'b0;
            end
            S_DRAIN: begin
                freeze_front = 1'b1;
            end
            S_FLUSH: begin
                flush        = 1'b1;
                freeze_front = 1'b1;
                freeze_back  = 1'b1;
            end
            S_WALK: begin
                walk_valid   = 1'b1;
                walk_cnt     = WCW'(walk_amt);
                freeze_front = 1'b1;
                freeze_back  = 1'b1;
            end
            S_REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = HANDLER_PC;
                freeze_front   = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign epc    = epc_q;
    assign ecause = ecause_q;

endmodule
